dice_lights_monitor: RTL and testbench

Synthesizable protocol checker sitting on the output side of the dice/traffic-lights multiplexer. It watches the same `button` and `sel` the multiplexer sees, plus its 3-bit `result`. Each cycle it predicts the next legal `result` and flags any deviation. It is used in benches and as an on-chip self-check, and it consumes exactly what the multiplexer produces.

---
 rtl/dice_lights_monitor.sv | 155 +++++++++++++++
 tb/tb_dice_lights_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dice_lights_monitor.sv
//------------------------------------------------------------------------------
// Module   : dice_lights_monitor
// Brief    : Protocol checker for the dice/traffic-lights multiplexer output.
//            Predicts each result from registered history and flags deviations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dice_lights_monitor #(
   parameter int ERR_CNT_W = 8,
   parameter int DICE_MAX  = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 button,
   input  logic                 sel,
   input  logic [2:0]           result,
   output logic                 in_sync,
   output logic [2:0]           expected,
   output logic                 err_pulse,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [2:0] C_DICE_MAX   = 3'(DICE_MAX);
   localparam logic [2:0] C_RED        = 3'b100;
   localparam logic [2:0] C_RED_AMBER  = 3'b110;
   localparam logic [2:0] C_GREEN      = 3'b001;
   localparam logic [2:0] C_AMBER      = 3'b010;
   localparam logic [ERR_CNT_W-1:0] C_CNT_MAX = {ERR_CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_WAIT  = 2'd0,
      S_SYNC  = 2'd1,
      S_TRACK = 2'd2
   } state_t;

   state_t               r_state;
   logic [2:0]           r_res_q;
   logic                 r_btn_q;
   logic                 r_sel_q;
   logic                 r_in_sync;
   logic                 r_err_pulse;
   logic                 r_err;
   logic [ERR_CNT_W-1:0] r_err_count;

   logic [2:0]           w_expected;
   logic                 w_legal;
   logic                 w_switch;
   logic                 w_mismatch;

   // Next legal result, derived only from last cycle's history.
   always_comb begin
      w_expected = r_res_q;
      if (r_sel_q) begin
         case (r_res_q)
            C_RED:       w_expected = C_RED_AMBER;
            C_RED_AMBER: w_expected = C_GREEN;
            C_GREEN:     w_expected = C_AMBER;
            default:     w_expected = C_RED;
         endcase
      end else if (r_btn_q) begin
         if ((r_res_q >= 3'd1) && (r_res_q < C_DICE_MAX))
            w_expected = r_res_q + 3'd1;
         else
            w_expected = 3'd1;
      end
   end

   // The sample under check was produced under the previous cycle's mode.
   always_comb begin
      w_legal = 1'b0;
      if (r_sel_q) begin
         w_legal = (result == C_RED) || (result == C_RED_AMBER) ||
                   (result == C_GREEN) || (result == C_AMBER);
      end else begin
         w_legal = (result >= 3'd1) && (result <= C_DICE_MAX) && (result != 3'd7);
      end
   end

   assign w_switch = (sel != r_sel_q);

   always_comb begin
      w_mismatch = 1'b0;
      case (r_state)
         S_WAIT:  w_mismatch = 1'b0;
         S_SYNC:  w_mismatch = !w_legal;
         S_TRACK: begin
            if (w_switch)
               w_mismatch = !w_legal;
            else
               w_mismatch = !w_legal || (result != w_expected);
         end
         default: w_mismatch = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_WAIT;
         r_res_q     <= 3'd0;
         r_btn_q     <= 1'b0;
         r_sel_q     <= 1'b0;
         r_in_sync   <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err       <= 1'b0;
         r_err_count <= '0;
      end else begin
         // History always follows the observed sample, so one fault never cascades.
         r_res_q <= result;
         r_btn_q <= button;
         r_sel_q <= sel;

         case (r_state)
            S_WAIT: begin
               r_state   <= S_SYNC;
               r_in_sync <= 1'b0;
            end
            S_SYNC: begin
               r_state   <= S_TRACK;
               r_in_sync <= 1'b1;
            end
            S_TRACK: begin
               if (w_switch) begin
                  r_state   <= S_SYNC;
                  r_in_sync <= 1'b0;
               end else begin
                  r_state   <= S_TRACK;
                  r_in_sync <= 1'b1;
               end
            end
            default: begin
               r_state   <= S_WAIT;
               r_in_sync <= 1'b0;
            end
         endcase

         r_err_pulse <= w_mismatch;
         if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_err_count != C_CNT_MAX)
               r_err_count <= r_err_count + ERR_CNT_W'(1);
         end
      end
   end

   assign in_sync   = r_in_sync;
   assign expected  = w_expected;
   assign err_pulse = r_err_pulse;
   assign err       = r_err;
   assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_dice_lights_monitor.sv
//------------------------------------------------------------------------------
// Module   : tb_dice_lights_monitor
// Brief    : Scoreboard bench for dice_lights_monitor with a reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dice_lights_monitor;

   localparam int CW   = 3;
   localparam int DMAX = 6;
   localparam int CMAX = (1 << CW) - 1;
   localparam logic [2:0] RING [4] = '{3'b100, 3'b110, 3'b001, 3'b010};

   logic          clk;
   logic          rst;
   logic          button;
   logic          sel;
   logic [2:0]    result;
   logic          in_sync;
   logic [2:0]    expected;
   logic          err_pulse;
   logic          err;
   logic [CW-1:0] err_count;

   dice_lights_monitor #(.ERR_CNT_W(CW), .DICE_MAX(DMAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .button    (button),
      .sel       (sel),
      .result    (result),
      .in_sync   (in_sync),
      .expected  (expected),
      .err_pulse (err_pulse),
      .err       (err),
      .err_count (err_count)
   );

   typedef struct packed {
      logic          in_sync;
      logic [2:0]    expected;
      logic          pulse;
      logic          err;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: samples accepted since the last baseline loss, plus history.
   int         m_b;
   logic [2:0] m_res;
   logic       m_btn;
   logic       m_sel;
   logic       m_pulse;
   logic       m_err;
   int         m_cnt;

   int         roll [8] = '{1, 2, 3, 4, 5, 6, 1, 2};
   int         tlseq [5] = '{4, 6, 1, 2, 4};
   logic       rr, rb, rs;
   logic [2:0] rv;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [2:0] predict(input logic [2:0] r, input logic b, input logic s);
      int v;
      v = int'(r);
      if (s) begin
         for (int i = 0; i < 4; i++)
            if (r == RING[i]) return RING[(i + 1) % 4];
         return RING[0];
      end
      if (!b) return r;
      if (v >= 1 && v <= DMAX) return 3'((v % DMAX) + 1);
      return 3'd1;
   endfunction

   function automatic logic legal(input logic [2:0] r, input logic s);
      if (s) begin
         for (int i = 0; i < 4; i++)
            if (r == RING[i]) return 1'b1;
         return 1'b0;
      end
      return (int'(r) >= 1) && (int'(r) <= DMAX);
   endfunction

   task automatic step(input logic r, input logic b, input logic s, input logic [2:0] res);
      logic bad;
      exp_t e;
      @(negedge clk);
      rst = r; button = b; sel = s; result = res;
      if (r) begin
         m_b = 0; m_res = 3'd0; m_btn = 1'b0; m_sel = 1'b0;
         m_pulse = 1'b0; m_err = 1'b0; m_cnt = 0;
      end else begin
         bad = 1'b0;
         if (m_b == 0)
            bad = 1'b0;
         else if (m_b == 1 || s != m_sel)
            bad = !legal(res, m_sel);
         else
            bad = !legal(res, m_sel) || (res != predict(m_res, m_btn, m_sel));
         if (m_b >= 2 && s != m_sel) m_b = 1;
         else if (m_b < 2) m_b = m_b + 1;
         m_pulse = bad;
         if (bad) begin
            m_err = 1'b1;
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
         end
         m_res = res; m_btn = b; m_sel = s;
      end
      e.in_sync  = (m_b == 2);
      e.expected = predict(m_res, m_btn, m_sel);
      e.pulse    = m_pulse;
      e.err      = m_err;
      e.cnt      = CW'(m_cnt);
      sb.push_back(e);
   endtask

   function automatic void chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
      end
   endfunction

   // Monitor: the DUT presents a fresh set of outputs after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("in_sync",   int'(in_sync),   int'(e.in_sync));
            chk("expected",  int'(expected),  int'(e.expected));
            chk("err_pulse", int'(err_pulse), int'(e.pulse));
            chk("err",       int'(err),       int'(e.err));
            chk("err_count", int'(err_count), int'(e.cnt));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; button = 1'b0; sel = 1'b0; result = 3'd0;

      step(1, 0, 0, 0);
      step(1, 0, 0, 0);

      // Dice roll
      foreach (roll[i]) step(0, 1, 0, 3'(roll[i]));
      step(0, 1, 0, 3);
      step(0, 0, 0, 4);
      repeat (4) step(0, 0, 0, 4);
      step(0, 0, 0, 5);
      step(0, 0, 0, 5);

      // Switch to traffic lights, full cycle, then an illegal value
      step(0, 0, 1, 5);
      foreach (tlseq[i]) step(0, 0, 1, 3'(tlseq[i]));
      step(0, 0, 1, 3'b111);
      step(0, 1, 1, 3'b100);
      step(0, 0, 1, 3'b110);

      // Back to dice with a button toggle on the switch cycle
      step(0, 1, 0, 3'b001);
      step(0, 1, 0, 2);
      step(0, 0, 0, 3);

      // Saturate the counter, then reset in the middle of the faults
      repeat (9) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 4);
      step(0, 1, 0, 5);
      step(0, 1, 0, 6);

      // Randomized segments driven by a well-behaved mux with injected faults
      for (int seg = 0; seg < 10; seg++) begin
         step(1, 0, 0, 0);
         rs = 1'($urandom_range(0, 1));
         for (int i = 0; i < 70; i++) begin
            rr = ($urandom_range(0, 59) == 0);
            rb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            rv = predict(m_res, m_btn, m_sel);
            if ($urandom_range(0, 6) == 0) rv = 3'($urandom_range(0, 7));
            step(rr, rb, rs, rv);
         end
      end

      repeat (2) @(posedge clk);
      #2;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
